// File: rtl/pipe_pkg.sv
// pipe_reg shared definitions.
// Default geometry, counter width and OCC width helper.
package pipe_pkg;

  localparam int PIPE_WIDTH_DEF = 20;
  localparam int PIPE_DEPTH_DEF = 2;
  localparam int PIPE_CNT_W     = 32;

  function automatic int occ_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_if.sv
// pipe_reg valid/ready channel.
// master drives data/valid, slave drives ready.
interface pipe_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEF
);

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/pipe_stage.sv
// pipe_reg single register slice.
// Loads when empty or when downstream drains.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_v,
  input  logic             rdy_nxt,
  output logic [WIDTH-1:0] d,
  output logic             v,
  output logic             rdy
);

  assign rdy = !v || rdy_nxt;

  // slice register: load on rdy, clear valid on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= '0;
      v <= 1'b0;
    end else begin
      if (rdy) d <= in_d;
      if (clr)      v <= 1'b0;
      else if (rdy) v <= in_v;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: elastic valid/ready pipeline of DEPTH slices.
// Define PIPE_STATS_EN to build the output transfer counter.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEF,
  parameter int DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  pipe_if.slave                   a,
  pipe_if.master                  y,
  output logic [occ_w(DEPTH)-1:0] occ,
  output logic [PIPE_CNT_W-1:0]   xfer_cnt
);

  localparam int OCC_W = occ_w(DEPTH);

  if (DEPTH == 0) begin : g_wire
    assign y.data  = a.data;
    assign y.valid = a.valid;
    assign a.ready = y.ready;
    assign occ     = '0;
  end else begin : g_pipe
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stg
      logic [WIDTH-1:0] in_d;
      logic             in_v;
      logic             rdy_n;

      if (i == 0) begin : g_head
        assign in_d = a.data;
        assign in_v = a.valid;
      end else begin : g_body
        assign in_d = d[i-1];
        assign in_v = v[i-1];
      end

      // downstream can take a word unless every later slice is full and stalled
      if (i == DEPTH - 1) begin : g_last
        assign rdy_n = y.ready;
      end else begin : g_mid
        assign rdy_n = y.ready || !(&v[DEPTH-1:i+1]);
      end

      pipe_stage #(
        .WIDTH(WIDTH)
      ) u_stg (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (flush),
        .in_d   (in_d),
        .in_v   (in_v),
        .rdy_nxt(rdy_n),
        .d      (d[i]),
        .v      (v[i]),
        .rdy    (rdy[i])
      );
    end

    assign a.ready = rst_n && !flush && rdy[0];
    assign y.data  = d[DEPTH-1];
    assign y.valid = v[DEPTH-1];

    // occupancy is a popcount of the valid flops only
    always_comb begin
      occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
        occ = occ + OCC_W'(v[i]);
      end
    end
  end

`ifdef PIPE_STATS_EN
  logic [PIPE_CNT_W-1:0] cnt_q;

  // output transfer counter, wraps, immune to flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (y.valid && y.ready) begin
      cnt_q <= cnt_q + PIPE_CNT_W'(1);
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// pipe_reg bench: DEPTH=2 and DEPTH=3 instances share stimulus.
// Each is scored against a queue model of words in flight.
module tb_pipe_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        a_valid = 1'b0;
  logic        y_ready = 1'b0;
  logic [19:0] a_data = '0;

  always #5 clk = ~clk;

  pipe_if #(.WIDTH(20)) a0 ();
  pipe_if #(.WIDTH(20)) y0 ();
  pipe_if #(.WIDTH(20)) a1 ();
  pipe_if #(.WIDTH(20)) y1 ();

  assign a0.data  = a_data;
  assign a0.valid = a_valid;
  assign y0.ready = y_ready;
  assign a1.data  = a_data;
  assign a1.valid = a_valid;
  assign y1.ready = y_ready;

  logic [1:0]  occ0, occ1;
  logic [31:0] cnt0, cnt1;

  pipe_reg #(.WIDTH(20), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .a(a0), .y(y0), .occ(occ0), .xfer_cnt(cnt0)
  );

  pipe_reg #(.WIDTH(20), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .a(a1), .y(y1), .occ(occ1), .xfer_cnt(cnt1)
  );

  logic        ordy [2];
  logic        oyv  [2];
  logic [19:0] oyd  [2];
  logic [1:0]  oocc [2];
  logic [31:0] ocnt [2];

  assign ordy[0] = a0.ready;
  assign ordy[1] = a1.ready;
  assign oyv[0]  = y0.valid;
  assign oyv[1]  = y1.valid;
  assign oyd[0]  = y0.data;
  assign oyd[1]  = y1.data;
  assign oocc[0] = occ0;
  assign oocc[1] = occ1;
  assign ocnt[0] = cnt0;
  assign ocnt[1] = cnt1;

  int          dep [2] = '{2, 3};
  logic [19:0] mem [2][4096];
  int          macc [2][4096];
  int          wr [2] = '{0, 0};
  int          rd [2] = '{0, 0};
  logic [31:0] ecnt [2] = '{0, 0};
  logic        pstall [2] = '{1'b0, 1'b0};
  logic [19:0] pd [2];
  int          cyc = 0;
  bit          exact_lat = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input int k);
    int    sz;
    int    hn;
    logic  er;
    string s;
    sz = wr[k] - rd[k];
    hn = macc[k][rd[k] % 4096];
    s  = $sformatf("d%0d", dep[k]);
    er = rst_n && !flush && (sz < dep[k] || y_ready);
    chk({s, ".a_ready"}, ordy[k], er);
    chk({s, ".occ"}, oocc[k], sz);
    chk({s, ".xfer_cnt"}, ocnt[k], ecnt[k]);
    if (pstall[k]) begin
      chk({s, ".hold_valid"}, oyv[k], 1);
      chk({s, ".hold_data"}, oyd[k], pd[k]);
    end
    if (sz == dep[k]) chk({s, ".full_valid"}, oyv[k], 1);
    if (sz == 0) chk({s, ".empty_valid"}, oyv[k], 0);
    if (exact_lat)
      chk({s, ".lat_valid"}, oyv[k], sz > 0 && cyc >= hn + dep[k] - 1);
    if (oyv[k] && sz > 0) begin
      chk({s, ".y_data"}, oyd[k], mem[k][rd[k] % 4096]);
      chk({s, ".not_early"}, cyc >= hn + dep[k] - 1, 1);
    end
    if (oyv[k] && y_ready && sz > 0) begin
      rd[k]++;
`ifdef PIPE_STATS_EN
      ecnt[k]++;
`endif
    end
    if (flush) rd[k] = wr[k];
    if (a_valid && er) begin
      mem[k][wr[k] % 4096]  = a_data;
      macc[k][wr[k] % 4096] = cyc + 1;
      wr[k]++;
    end
    pstall[k] = oyv[k] && !y_ready && !flush;
    pd[k]     = oyd[k];
  endtask

  task automatic tick();
    @(negedge clk);
    model_step(0);
    model_step(1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.d%0d.y_valid", tag, dep[k]), oyv[k], 0);
      chk($sformatf("%s.d%0d.y", tag, dep[k]), oyd[k], 0);
      chk($sformatf("%s.d%0d.occ", tag, dep[k]), oocc[k], 0);
      chk($sformatf("%s.d%0d.cnt", tag, dep[k]), ocnt[k], 0);
      chk($sformatf("%s.d%0d.a_ready", tag, dep[k]), ordy[k], 0);
    end
  endtask

  task automatic mid_reset();
    #1 rst_n = 1'b0;
    #1 reset_checks("mid_rst");
    for (int k = 0; k < 2; k++) begin
      rd[k]     = wr[k];
      ecnt[k]   = '0;
      pstall[k] = 1'b0;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 reset_checks("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    exact_lat = 1'b1;
    y_ready   = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      a_valid = 1'b1;
      a_data  = 20'(i);
      tick();
    end
    a_valid = 1'b0;
    repeat (5) tick();
    exact_lat = 1'b0;

    y_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1;
      a_data  = 20'h100 + 20'(i);
      tick();
    end
    a_valid = 1'b0;
    y_ready = 1'b1;
    repeat (6) tick();

    y_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_valid = 1'b1;
      a_data  = 20'h200 + 20'(i);
      tick();
    end
    chk("pre_flush.d2.occ", occ0, 2);
    chk("pre_flush.d3.occ", occ1, 2);
    flush   = 1'b1;
    a_data  = 20'hABCDE;
    tick();
    flush   = 1'b0;
    a_valid = 1'b0;
    #1;
    chk("post_flush.d2.occ", occ0, 0);
    chk("post_flush.d3.occ", occ1, 0);
    chk("post_flush.d2.y_valid", y0.valid, 0);
    chk("post_flush.d3.y_valid", y1.valid, 0);
    y_ready = 1'b1;
    repeat (4) tick();

    begin
      int  acc;
      int  n;
      acc = 0;
      n   = 0;
      while (acc < 1000 && n < 6000) begin
        a_valid = n[0] == 1'b0;
        a_data  = 20'($urandom);
        y_ready = $urandom_range(0, 3) != 0;
        flush   = $urandom_range(0, 99) == 0;
        if (n == 700) mid_reset();
        if (a_valid && a0.ready) acc++;
        tick();
        n++;
      end
      flush = 1'b0;
      chk("random.budget", n < 6000, 1);
    end

    a_valid = 1'b0;
    y_ready = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1;
      a_data  = 20'h300 + 20'(i);
      tick();
    end
`ifdef PIPE_STATS_EN
    force u_d2.cnt_q = 32'hFFFF_FFFE;
    force u_d3.cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_d2.cnt_q;
    release u_d3.cnt_q;
    ecnt[0] = 32'hFFFF_FFFE;
    ecnt[1] = 32'hFFFF_FFFE;
    repeat (3) tick();
    chk("wrap.d2.cnt", cnt0, 1);
    chk("wrap.d3.cnt", cnt1, 1);
`else
    repeat (3) tick();
    chk("nostats.d2.cnt", cnt0, 0);
    chk("nostats.d3.cnt", cnt1, 0);
`endif
    flush = 1'b1;
    tick();
    flush   = 1'b0;
    a_valid = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1;
      a_data  = 20'h400 + 20'(i);
      tick();
    end
    a_valid = 1'b0;
    repeat (6) tick();
    chk("drain.d2.occ", occ0, 0);
    chk("drain.d3.occ", occ1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
